// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared helpers for the adder family: a clog2 function and a
//                macro that rejects a WIDTH that is not a multiple of BLOCK.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef ADDER_PKG_CHECK_MACROS
`define ADDER_PKG_CHECK_MACROS
// Elaboration-time guard: a slice width that does not tile the operand is illegal.
`define ADDER_CHECK_BLOCK_DIVIDES(W, B) \
    if (((W) % (B)) != 0) begin : g_bad_block_size \
        $fatal(1, "adder: WIDTH must be a multiple of BLOCK"); \
    end
`endif

package adder_pkg;

    // Ceiling log2, for sizing counters and indices in adder variants.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// ============================================================================
//  Module      : cla_block
//  Description : Combinational BLOCK-bit carry-lookahead slice. Every carry is
//                expanded as a flat sum of generate/propagate products so no
//                carry depends on a rippled neighbour.
//  Revision    : 1.0  initial release
// ============================================================================

module cla_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK:0]   w_c;
    logic             w_run;
    logic             w_term;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        w_c    = '0;
        w_run  = 1'b0;
        w_term = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            w_term = w_g[i];
            w_run  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                w_run  = w_run & w_p[j+1];
                w_term = w_term | (w_run & w_g[j]);
            end
            w_run      = w_run & w_p[0];
            w_c[i+1]   = w_term | (w_run & cin);
        end
    end

    assign sum      = w_p ^ w_c[BLOCK-1:0];
    assign cout     = w_c[BLOCK];
    assign c_msb_in = w_c[BLOCK-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : WIDTH-bit adder/subtractor split into BLOCK-bit lookahead
//                slices, one slice per pipeline stage, with a global-enable
//                valid/ready pipeline. Reports carry-out and signed overflow.
//  Revision    : 1.0  initial release
// ============================================================================

module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NUM_STAGES = WIDTH / BLOCK;

    `ADDER_CHECK_BLOCK_DIVIDES(WIDTH, BLOCK)

    logic                  w_adv;
    logic [WIDTH-1:0]      w_b_eff;
    logic                  w_c0;

    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] r_carry;
    logic                  r_ovf;
    logic [WIDTH-1:0]      r_a     [NUM_STAGES];
    logic [WIDTH-1:0]      r_b     [NUM_STAGES];
    logic [WIDTH-1:0]      r_sum   [NUM_STAGES];

    logic [WIDTH-1:0]      w_next_sum   [NUM_STAGES];
    logic [BLOCK-1:0]      w_slice_sum  [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_slice_cout;
    logic                  w_slice_cmsb [NUM_STAGES];

    // Whole pipeline moves together whenever the output register is free or draining.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Subtraction is A + ~B + 1, so the incoming carry is forced high.
    assign w_b_eff = in_sub ? ~in_b : in_b;
    assign w_c0    = in_sub | in_cin;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] c_SLICE_MASK = WIDTH'({BLOCK{1'b1}}) << (k * BLOCK);

        logic [BLOCK-1:0] w_sa;
        logic [BLOCK-1:0] w_sb;
        logic             w_ci;

        if (k == 0) begin : g_first
            assign w_sa          = in_a[BLOCK-1:0];
            assign w_sb          = w_b_eff[BLOCK-1:0];
            assign w_ci          = w_c0;
            assign w_next_sum[k] = WIDTH'(w_slice_sum[k]);
        end else begin : g_next
            assign w_sa          = r_a[k-1][k*BLOCK +: BLOCK];
            assign w_sb          = r_b[k-1][k*BLOCK +: BLOCK];
            assign w_ci          = r_carry[k-1];
            // Resolved lower bits ride along; this slice fills in its own window.
            assign w_next_sum[k] = (r_sum[k-1] & ~c_SLICE_MASK)
                                 | (WIDTH'(w_slice_sum[k]) << (k * BLOCK));
        end

        cla_block #(
            .BLOCK (BLOCK)
        ) u_cla (
            .a        (w_sa),
            .b        (w_sb),
            .cin      (w_ci),
            .sum      (w_slice_sum[k]),
            .cout     (w_slice_cout[k]),
            .c_msb_in (w_slice_cmsb[k])
        );
    end

    // Stage registers: valid chain, operand skew, partial sums and slice carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            r_a[0]     <= in_a;
            r_b[0]     <= w_b_eff;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_a[k]     <= r_a[k-1];
                r_b[k]     <= r_b[k-1];
            end
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_sum[k] <= w_next_sum[k];
            end
            r_carry <= w_slice_cout;
            r_ovf   <= w_slice_cmsb[NUM_STAGES-1] ^ w_slice_cout[NUM_STAGES-1];
        end
    end

    assign out_valid = r_valid[NUM_STAGES-1];
    assign out_sum   = r_sum[NUM_STAGES-1];
    assign out_cout  = r_carry[NUM_STAGES-1];
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cla_adder
//  Description : Self-checking bench for pipelined_cla_adder (32-bit, 8-bit
//                slices). Expected results come from plain wide arithmetic
//                held in a FIFO in acceptance order.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_pipelined_cla_adder;

    localparam int WIDTH      = 32;
    localparam int BLOCK      = 8;
    localparam int NUM_STAGES = WIDTH / BLOCK;

    typedef logic [WIDTH+1:0] res_t;   // {ovf, cout, sum}

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_cin    = 1'b0;
    logic             in_sub    = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_cout;
    logic             out_ovf;
    logic [WIDTH-1:0] out_sum;

    pipelined_cla_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   n_pop  = 0;
    bit   lat_chk  = 1'b0;
    bit   dir_mode = 1'b0;
    bit   last_acc = 1'b0;
    bit   h_pend   = 1'b0;
    res_t dir_exp;
    res_t h_val;
    res_t exp_q [$];
    int   acc_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {cout,sum} = A + B' + c0 in WIDTH+1 bits; overflow when the
    // operands share a sign and the result sign differs.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bo;
        logic [WIDTH:0]   t;
        logic             c0;
        logic             ovf;
        bo  = sub ? ~b : b;
        c0  = sub ? 1'b1 : cin;
        t   = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, c0};
        ovf = (a[WIDTH-1] == bo[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return {ovf, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    // One clock: observe handshakes with inputs settled, then advance past the edge.
    task tick;
        res_t e;
        int   t0;
        #1;
        if (h_pend) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({out_ovf, out_cout, out_sum}), 64'(h_val));
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(dir_mode ? dir_exp : model(in_a, in_b, in_cin, in_sub));
            acc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e  = exp_q.pop_front();
                t0 = acc_q.pop_front();
                n_pop++;
                check("sum",  64'(out_sum),  64'(e[WIDTH-1:0]));
                check("cout", 64'(out_cout), 64'(e[WIDTH]));
                check("ovf",  64'(out_ovf),  64'(e[WIDTH+1]));
                if (lat_chk) check("latency", 64'(cyc - t0), 64'(NUM_STAGES));
            end
        end
        h_pend = out_valid && !out_ready;
        h_val  = {out_ovf, out_cout, out_sum};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                  input logic sub, input logic [WIDTH-1:0] esum, input logic ecout,
                  input logic eovf);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        dir_mode  = 1'b1;
        dir_exp   = {eovf, ecout, esum};
        lat_chk   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (last_acc) break;
        end
        in_valid = 1'b0;
        dir_mode = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick;
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        lat_chk = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    int idx;
    bit seen;
    int stall;
    int pops0;
    int stale;
    int n_acc;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner vectors with fixed expected values and latency
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_one(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);

        // Back-to-back beats with a 3-cycle output stall after first result
        idx   = 0;
        seen  = 1'b0;
        stall = 3;
        pops0 = n_pop;
        for (int c = 0; c < 60; c++) begin
            if (idx >= 6 && exp_q.size() == 0) break;
            in_valid = (idx < 6);
            in_a     = idx;
            in_b     = idx;
            in_cin   = 1'b0;
            in_sub   = 1'b0;
            if (out_valid) seen = 1'b1;
            if (seen && stall > 0) begin
                out_ready = 1'b0;
                stall--;
                #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end else begin
                out_ready = 1'b1;
            end
            tick;
            if (last_acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_beats_in",  64'(idx), 64'd6);
        check("bp_beats_out", 64'(n_pop - pops0), 64'd6);

        // Asynchronous reset with three beats in flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a   = $urandom;
            in_b   = $urandom;
            in_sub = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum",   64'(out_sum),   64'd0);
        exp_q.delete();
        acc_q.delete();
        h_pend = 1'b0;
        #2;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            tick;
        end
        check("no_stale_after_rst", 64'(stale), 64'd0);
        send_one(32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

        // Randomized traffic with random valid and backpressure
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_a = 32'hFFFF_FFFF;
                1:       in_a = 32'h7FFF_FFFF;
                2:       in_a = 32'h8000_0000;
                default: in_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       in_b = 32'h0000_0000;
                1:       in_b = 32'h0000_0001;
                2:       in_b = 32'hFFFF_FFFF;
                default: in_b = $urandom;
            endcase
            in_cin = 1'($urandom_range(0, 1));
            in_sub = 1'($urandom_range(0, 1));
            tick;
            if (last_acc) n_acc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick;
        check("rand_drain", 64'(exp_q.size()), 64'd0);
        check("rand_beats", 64'(n_acc), 64'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
